// File: rtl/uart_block_packer.sv
// uart_block_packer: packs UART bytes into 64-bit cipher blocks, padding idle partial blocks.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready        8-bit byte stream from the UART receiver
//   m_axis_tdata/tkeep/tvalid/tready  64-bit block stream to the cipher, tkeep marks received lanes
//   padded_blocks                     wrapping count of blocks emitted with padding
module uart_block_packer #(
    parameter int          TIMEOUT_CYCLES = 86800,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] padded_blocks
);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic {COLLECT, OUT} state_t;
    state_t state;
    logic [2:0] idx;
    logic [TW-1:0] timer;
    logic s_hs, expire;
    assign s_hs = s_axis_tvalid & s_axis_tready;
    // Only a partial block (idx != 0) can time out; a zero timeout never expires.
    assign expire = (TIMEOUT_CYCLES != 0) && (idx != 3'd0) && (timer == T_LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COLLECT;
            idx           <= 3'd0;
            timer         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            padded_blocks <= '0;
        end else if (state == COLLECT) begin
            s_axis_tready <= 1'b1;
            // A byte arriving on the expiry cycle wins over padding.
            if (s_hs) begin
                m_axis_tdata[{idx, 3'b000} +: 8] <= s_axis_tdata;
                m_axis_tkeep[idx] <= 1'b1;
                idx   <= idx + 3'd1;
                timer <= '0;
                if (idx == 3'd7) begin
                    state         <= OUT;
                    m_axis_tvalid <= 1'b1;
                    s_axis_tready <= 1'b0;
                end
            end else if (expire) begin
                for (int i = 0; i < 8; i++)
                    if (3'(i) >= idx) m_axis_tdata[i*8 +: 8] <= PAD_BYTE;
                padded_blocks <= padded_blocks + 16'd1;
                idx           <= 3'd0;
                timer         <= '0;
                state         <= OUT;
                m_axis_tvalid <= 1'b1;
                s_axis_tready <= 1'b0;
            end else if (idx != 3'd0 && TIMEOUT_CYCLES != 0) begin
                timer <= timer + 1'b1;
            end
        end else if (m_axis_tready) begin
            state         <= COLLECT;
            m_axis_tvalid <= 1'b0;
            m_axis_tkeep  <= '0;
            timer         <= '0;
            s_axis_tready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_block_packer.sv
// tb_uart_block_packer: randomized scoreboard bench for uart_block_packer.
module tb_uart_block_packer;
    localparam int         TO  = 16;
    localparam logic [7:0] PAD = 8'hFF;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic s_tvalid = 1'b0, s_tready;
    logic [63:0] m_tdata;
    logic [7:0] m_tkeep;
    logic m_tvalid, m_tready = 1'b1;
    logic [15:0] padded;
    always #5 clk = ~clk;
    uart_block_packer #(.TIMEOUT_CYCLES(TO), .PAD_BYTE(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .padded_blocks(padded)
    );
    typedef struct packed { logic [63:0] d; logic [7:0] k; } blk_t;
    blk_t sb[$];
    logic [7:0] part[$];
    int vectors = 0, errors = 0, idle = 0;
    bit alive = 0, busy = 0, rnd_rdy = 0;
    logic [15:0] exp_pad = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask
    // Reference block: received bytes in arrival order from lane 0, PAD elsewhere.
    function automatic blk_t make_blk();
        blk_t b;
        for (int i = 0; i < 8; i++) begin
            b.d[i*8 +: 8] = i < part.size() ? part[i] : PAD;
            b.k[i] = i < part.size();
        end
        return b;
    endfunction
    // Reference model: evaluated at each negedge, deciding what the coming posedge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tvalid", m_tvalid, 0);
            check("rst_tready", s_tready, 0);
            check("rst_tkeep", m_tkeep, 0);
            check("rst_tdata", m_tdata, 0);
            check("rst_padded", padded, 0);
            alive = 0; busy = 0; idle = 0; exp_pad = 0;
            sb.delete(); part.delete();
        end else begin
            check("s_tready", s_tready, alive && !busy);
            check("m_tvalid", m_tvalid, busy);
            check("padded", padded, exp_pad);
            if (busy) begin
                if (m_tready) busy = 0;
            end else if (alive && s_tvalid) begin
                part.push_back(s_tdata);
                idle = 0;
                if (part.size() == 8) begin
                    sb.push_back(make_blk());
                    part.delete();
                    busy = 1;
                end
            end else if (alive && part.size() > 0) begin
                idle++;
                if (idle == TO) begin
                    sb.push_back(make_blk());
                    part.delete();
                    idle = 0;
                    exp_pad++;
                    busy = 1;
                end
            end
            alive = 1;
        end
    end
    // Monitor: compares any presented block against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && m_tvalid) begin
            if (sb.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_block: got %h expected no block", m_tdata);
            end else begin
                check("tdata", m_tdata, sb[0].d);
                check("tkeep", m_tkeep, sb[0].k);
                if (m_tready) void'(sb.pop_front());
            end
        end
    end
    always begin
        @(posedge clk); #1;
        if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
    end
    task automatic send(input logic [7:0] b);
        s_tdata = b; s_tvalid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_tready) break;
            if (n > 300) begin
                vectors++; errors++;
                $display("FAIL send_timeout: got tready=0 required 1 for byte %h", b);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
    endtask
    initial begin
        #1 do_reset();
        wait_cycles(2);
        for (int i = 1; i <= 8; i++) send(8'(i));
        wait_cycles(4);
        send(8'hAA); send(8'hBB); send(8'hCC);
        wait_cycles(TO + 6);
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        fork
            begin wait_cycles(20); m_tready = 1'b1; end
            for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        join
        wait_cycles(4);
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
        wait_cycles(TO - 1);
        for (int i = 5; i < 8; i++) send(8'h40 + 8'(i));
        wait_cycles(4);
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'h10 + 8'(i));
        wait_cycles(4);
        send(8'h5A);
        wait_cycles(TO + 6);
        rnd_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom));
            if ($urandom_range(0, 3) != 0) wait_cycles($urandom_range(0, TO + 4));
        end
        rnd_rdy = 0;
        @(posedge clk); #1 m_tready = 1'b1;
        wait_cycles(TO + 20);
        check("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1, "watchdog expired");
    end
endmodule
